// File: rtl/mc_main_ctrl.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/write-back,
// drives all datapath enables and selects, and counts retired instructions.
module mc_main_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [5:0]  op_i,
    input  logic        mem_ready_i,
    output logic        PCWrite_o,
    output logic        PCWriteCond_o,
    output logic        IorD_o,
    output logic        MemRead_o,
    output logic        MemWrite_o,
    output logic        IRWrite_o,
    output logic        MemtoReg_o,
    output logic        RegDst_o,
    output logic        RegWrite_o,
    output logic        ALUSrcA_o,
    output logic [1:0]  ALUSrcB_o,
    output logic [2:0]  ALUOp_o,
    output logic [1:0]  PCSource_o,
    output logic        illegal_o,
    output logic [3:0]  state_o,
    output logic [31:0] retired_o
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StRtWb   = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9,
        StAddiEx = 4'd10,
        StAddiWb = 4'd11
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;

    state_e      r_state;
    state_e      w_state_d;
    logic [31:0] r_retired;
    logic        w_retire;
    logic        w_op_legal;
    logic        w_from_final;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= StFetch;
            r_retired <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_retire) begin
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    always_comb begin
        w_op_legal = 1'b0;
        case (op_i)
            OpRtype, OpLw, OpSw, OpBeq, OpJ, OpAddi: w_op_legal = 1'b1;
            default:                                 w_op_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_state_d = StFetch;
        case (r_state)
            StFetch:  w_state_d = mem_ready_i ? StDecode : StFetch;
            StDecode: begin
                case (op_i)
                    OpRtype:     w_state_d = StExec;
                    OpLw, OpSw:  w_state_d = StMemAdr;
                    OpBeq:       w_state_d = StBranch;
                    OpJ:         w_state_d = StJump;
                    OpAddi:      w_state_d = StAddiEx;
                    default:     w_state_d = StFetch;
                endcase
            end
            StMemAdr: w_state_d = (op_i == OpSw) ? StMemWr : StMemRd;
            StMemRd:  w_state_d = mem_ready_i ? StMemWb : StMemRd;
            StMemWr:  w_state_d = mem_ready_i ? StFetch : StMemWr;
            StExec:   w_state_d = StRtWb;
            StAddiEx: w_state_d = StAddiWb;
            default:  w_state_d = StFetch;
        endcase
    end

    // Only completed instructions count; an illegal opcode leaves from DECODE and is excluded.
    always_comb begin
        w_from_final = 1'b0;
        case (r_state)
            StMemWb, StMemWr, StRtWb, StAddiWb, StBranch, StJump: w_from_final = 1'b1;
            default:                                              w_from_final = 1'b0;
        endcase
    end

    assign w_retire = w_from_final && (w_state_d == StFetch);

    always_comb begin
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        IorD_o        = 1'b0;
        MemRead_o     = 1'b0;
        MemWrite_o    = 1'b0;
        IRWrite_o     = 1'b0;
        MemtoReg_o    = 1'b0;
        RegDst_o      = 1'b0;
        RegWrite_o    = 1'b0;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = 2'b00;
        ALUOp_o       = 3'b000;
        PCSource_o    = 2'b00;
        illegal_o     = 1'b0;
        // Reset holds the state at FETCH, so its strobes must be masked explicitly.
        if (!rst_i) begin
            case (r_state)
                StFetch: begin
                    MemRead_o = 1'b1;
                    ALUSrcB_o = 2'b01;
                    IRWrite_o = mem_ready_i;
                    PCWrite_o = mem_ready_i;
                end
                StDecode: begin
                    ALUSrcB_o = 2'b11;
                    illegal_o = !w_op_legal;
                end
                StMemAdr, StAddiEx: begin
                    ALUSrcA_o = 1'b1;
                    ALUSrcB_o = 2'b10;
                end
                StMemRd: begin
                    MemRead_o = 1'b1;
                    IorD_o    = 1'b1;
                end
                StMemWr: begin
                    MemWrite_o = 1'b1;
                    IorD_o     = 1'b1;
                end
                StMemWb: begin
                    RegWrite_o = 1'b1;
                    MemtoReg_o = 1'b1;
                end
                StExec: begin
                    ALUSrcA_o = 1'b1;
                    ALUOp_o   = 3'b010;
                end
                StRtWb: begin
                    RegWrite_o = 1'b1;
                    RegDst_o   = 1'b1;
                end
                StAddiWb: begin
                    RegWrite_o = 1'b1;
                end
                StBranch: begin
                    ALUSrcA_o     = 1'b1;
                    ALUOp_o       = 3'b001;
                    PCWriteCond_o = 1'b1;
                    PCSource_o    = 2'b01;
                end
                StJump: begin
                    PCWrite_o  = 1'b1;
                    PCSource_o = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign state_o   = r_state;
    assign retired_o = r_retired;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Self-checking bench for mc_main_ctrl: per-instruction state paths with random memory waits,
// checked every cycle against a table-driven model, plus directed literal checks.
module tb_mc_main_ctrl;

    logic        clk;
    logic        rst_i;
    logic [5:0]  op_i;
    logic        mem_ready_i;
    logic        PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o;
    logic        MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o;
    logic [1:0]  ALUSrcB_o;
    logic [2:0]  ALUOp_o;
    logic [1:0]  PCSource_o;
    logic        illegal_o;
    logic [3:0]  state_o;
    logic [31:0] retired_o;

    mc_main_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .op_i         (op_i),
        .mem_ready_i  (mem_ready_i),
        .PCWrite_o    (PCWrite_o),
        .PCWriteCond_o(PCWriteCond_o),
        .IorD_o       (IorD_o),
        .MemRead_o    (MemRead_o),
        .MemWrite_o   (MemWrite_o),
        .IRWrite_o    (IRWrite_o),
        .MemtoReg_o   (MemtoReg_o),
        .RegDst_o     (RegDst_o),
        .RegWrite_o   (RegWrite_o),
        .ALUSrcA_o    (ALUSrcA_o),
        .ALUSrcB_o    (ALUSrcB_o),
        .ALUOp_o      (ALUOp_o),
        .PCSource_o   (PCSource_o),
        .illegal_o    (illegal_o),
        .state_o      (state_o),
        .retired_o    (retired_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Packed order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite
    // ALUSrcA ALUSrcB[1:0] ALUOp[2:0] PCSource[1:0]
    function automatic logic [16:0] exp_outs(input int s, input logic rdy);
        logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rdst = 0;
        logic rw = 0, srca = 0;
        logic [1:0] srcb = 0, pcsrc = 0;
        logic [2:0] aluop = 0;
        case (s)
            0:  begin mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
            1:  srcb = 2'b11;
            2, 10: begin srca = 1; srcb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            5:  begin mwr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            6:  begin srca = 1; aluop = 3'b010; end
            7:  begin rw = 1; rdst = 1; end
            11: rw = 1;
            8:  begin srca = 1; aluop = 3'b001; pcwc = 1; pcsrc = 2'b01; end
            9:  begin pcw = 1; pcsrc = 2'b10; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aluop, pcsrc};
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    endfunction

    int path_q[$];
    function automatic void build_path(input logic [5:0] op);
        path_q = {0, 1};
        case (op)
            6'h00: path_q = {path_q, 6, 7};
            6'h23: path_q = {path_q, 2, 3, 4};
            6'h2B: path_q = {path_q, 2, 5};
            6'h04: path_q.push_back(8);
            6'h02: path_q.push_back(9);
            6'h08: path_q = {path_q, 10, 11};
            default: ;
        endcase
    endfunction

    // Current-cycle expectations, consumed by the compare process.
    logic        chk_en = 1'b0;
    int          e_state;
    logic        e_rdy;
    logic        e_ill;
    logic [31:0] m_retired = '0;
    int          irw_cnt = 0, pcw_cnt = 0, ill_cnt = 0, rw_cnt = 0, mw_cnt = 0, mwr_hold = 0;

    logic [16:0] w_dut_outs;
    assign w_dut_outs = {PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
                         MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o,
                         PCSource_o};

    always @(negedge clk) begin
        if (chk_en) begin
            check("state", {28'd0, state_o}, e_state);
            check("outputs", {15'd0, w_dut_outs}, {15'd0, exp_outs(e_state, e_rdy)});
            check("illegal", {31'd0, illegal_o}, {31'd0, e_ill});
            check("retired", retired_o, m_retired);
            irw_cnt += int'(IRWrite_o);
            pcw_cnt += int'(PCWrite_o);
            ill_cnt += int'(illegal_o);
            rw_cnt  += int'(RegWrite_o);
            mw_cnt  += int'(MemWrite_o);
        end
    end

    task automatic step(input int s, input logic rdy, input logic ill);
        mem_ready_i = rdy;
        e_state     = s;
        e_rdy       = rdy;
        e_ill       = ill;
        chk_en      = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input int w_fetch, input int w_mem,
                             output int cycles);
        int nw;
        cycles = 0;
        op_i = op;
        build_path(op);
        foreach (path_q[i]) begin
            nw = (path_q[i] == 0) ? w_fetch : (path_q[i] == 3 || path_q[i] == 5) ? w_mem : 0;
            if (path_q[i] inside {0, 3, 5}) begin
                for (int k = 0; k <= nw; k++) begin
                    step(path_q[i], k == nw, 1'b0);
                    cycles++;
                end
            end else begin
                step(path_q[i], 1'($urandom_range(0, 1)), path_q[i] == 1 && !is_legal(op));
                cycles++;
            end
        end
        if (is_legal(op)) m_retired = m_retired + 32'd1;
    endtask

    initial begin
        int cyc, irw0, pcw0, ill0, rw0, mw0;
        logic [31:0] ret0;
        logic [5:0]  rop;
        rst_i = 1'b1;
        op_i = 6'h00;
        mem_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", {28'd0, state_o}, 32'd0);
        check("rst_memread", {31'd0, MemRead_o}, 32'd0);
        check("rst_irwrite", {31'd0, IRWrite_o}, 32'd0);
        check("rst_pcwrite", {31'd0, PCWrite_o}, 32'd0);
        check("rst_retired", retired_o, 32'd0);
        rst_i = 1'b0;
        #1;
        check("post_rst_memread", {31'd0, MemRead_o}, 32'd1);
        check("post_rst_srcb", {30'd0, ALUSrcB_o}, 32'd1);

        // R-type, zero wait
        run_instr(6'h00, 0, 0, cyc);
        check("rtype_cycles", cyc, 32'd4);
        check("rtype_retired", retired_o, 32'd1);

        // lw with two wait cycles in FETCH and MEMRD
        irw0 = irw_cnt; pcw0 = pcw_cnt;
        run_instr(6'h23, 2, 2, cyc);
        check("lw_cycles", cyc, 32'd9);
        check("lw_irwrite_pulses", irw_cnt - irw0, 32'd1);
        check("lw_pcwrite_pulses", pcw_cnt - pcw0, 32'd1);

        // sw (held two cycles), beq, j
        ret0 = retired_o; mw0 = mw_cnt;
        run_instr(6'h2B, 0, 2, cyc);
        check("sw_cycles", cyc, 32'd6);
        check("sw_memwrite_cycles", mw_cnt - mw0, 32'd3);
        run_instr(6'h04, 0, 0, cyc);
        check("beq_cycles", cyc, 32'd3);
        run_instr(6'h02, 0, 0, cyc);
        check("j_cycles", cyc, 32'd3);
        check("sw_beq_j_retired", retired_o - ret0, 32'd3);

        // illegal opcode
        ret0 = retired_o; ill0 = ill_cnt; rw0 = rw_cnt; mw0 = mw_cnt;
        run_instr(6'h3F, 0, 0, cyc);
        check("illegal_cycles", cyc, 32'd2);
        check("illegal_pulses", ill_cnt - ill0, 32'd1);
        check("illegal_no_regwrite", rw_cnt - rw0, 32'd0);
        check("illegal_no_memwrite", mw_cnt - mw0, 32'd0);
        check("illegal_retired", retired_o, ret0);

        // randomized instruction mix with random waits
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 7))
                0: rop = 6'h00;
                1: rop = 6'h23;
                2: rop = 6'h2B;
                3: rop = 6'h04;
                4: rop = 6'h02;
                5: rop = 6'h08;
                default: rop = 6'($urandom_range(0, 63));
            endcase
            run_instr(rop, $urandom_range(0, 3), $urandom_range(0, 3), cyc);
        end

        // reset asserted mid-MEMRD
        op_i = 6'h23;
        step(0, 1'b1, 1'b0);
        step(1, 1'b1, 1'b0);
        step(2, 1'b1, 1'b0);
        mem_ready_i = 1'b0;
        e_state = 3; e_rdy = 1'b0; e_ill = 1'b0;
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        rst_i = 1'b1;
        #1;
        check("midrst_state", {28'd0, state_o}, 32'd0);
        check("midrst_retired", retired_o, 32'd0);
        check("midrst_memread", {31'd0, MemRead_o}, 32'd0);
        m_retired = '0;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        #1;
        check("midrst_rel_memread", {31'd0, MemRead_o}, 32'd1);
        check("midrst_rel_srcb", {30'd0, ALUSrcB_o}, 32'd1);
        check("midrst_rel_state", {28'd0, state_o}, 32'd0);

        // counter wrap through one addi
        force dut.r_retired = 32'hFFFF_FFFF;
        #1;
        release dut.r_retired;
        m_retired = 32'hFFFF_FFFF;
        check("wrap_preload", retired_o, 32'hFFFF_FFFF);
        run_instr(6'h08, 0, 0, cyc);
        check("addi_cycles", cyc, 32'd4);
        check("wrap_retired", retired_o, 32'd0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
